// File: rtl/hit_responder_if.sv
// Bundles the collision-side inputs and the game-consequence outputs of
// hit_responder. The master drives the frame/hit/restart strobes and observes
// the results. The slave is the responder itself.
interface hit_responder_if #(
  parameter int LIVES_W = 3,
  parameter int SCORE_W = 10
);
  logic               startOfFrame;
  logic               hitPulse;
  logic               hitObj1;
  logic               hitObj2;
  logic               restart;
  logic [LIVES_W-1:0] lives;
  logic [SCORE_W-1:0] score;
  logic               bounce;
  logic               invulnerable;
  logic               ballVisible;
  logic               gameOver;

  modport master (
    output startOfFrame, hitPulse, hitObj1, hitObj2, restart,
    input  lives, score, bounce, invulnerable, ballVisible, gameOver
  );

  modport slave (
    input  startOfFrame, hitPulse, hitObj1, hitObj2, restart,
    output lives, score, bounce, invulnerable, ballVisible, gameOver
  );
endinterface

// File: rtl/hit_responder.sv
// hit_responder: turns per-frame collision pulses into lives, score, bounce
// requests, a blinking invulnerability window and game-over/restart.
// Every output comes straight from a register.
module hit_responder #(
  parameter int INIT_LIVES    = 3,
  parameter int LIVES_W       = 3,
  parameter int SCORE_W       = 10,
  parameter int POINTS        = 5,
  parameter int INVULN_FRAMES = 30,
  parameter int BLINK_FRAMES  = 4
) (
  input  logic            clk,
  input  logic            reset,
  hit_responder_if.slave  hr
);

  localparam logic [1:0] ST_PLAY   = 2'd0;
  localparam logic [1:0] ST_INVULN = 2'd1;
  localparam logic [1:0] ST_OVER   = 2'd2;

  localparam int FC_W = $clog2(INVULN_FRAMES + 1);
  localparam int BC_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(INIT_LIVES);
  localparam logic [LIVES_W-1:0] LIVES_ONE  = LIVES_W'(1);
  localparam logic [FC_W-1:0]    FC_LOAD    = FC_W'(INVULN_FRAMES);
  localparam logic [FC_W-1:0]    FC_ONE     = FC_W'(1);
  localparam logic [BC_W-1:0]    BC_ONE     = BC_W'(1);
  localparam logic [BC_W-1:0]    BC_LAST    = BC_W'(BLINK_FRAMES - 1);
  localparam logic [SCORE_W:0]   PTS        = (SCORE_W + 1)'(POINTS);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  logic [1:0]         state_q, state_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               bounce_q, bounce_d;
  logic               inv_q, inv_d;
  logic               vis_q, vis_d;
  logic               over_q, over_d;
  logic [FC_W-1:0]    fc_q, fc_d;
  logic [BC_W-1:0]    bc_q, bc_d;

  logic               dmg_hit;
  logic               rew_hit;
  logic               any_hit;
  logic [SCORE_W:0]   score_sum;
  logic [SCORE_W-1:0] score_sat;

  // Decode the hit qualifiers and the saturating score increment.
  always_comb begin
    dmg_hit   = hr.hitPulse & hr.hitObj1;
    rew_hit   = hr.hitPulse & hr.hitObj2 & ~hr.hitObj1;
    any_hit   = hr.hitPulse & (hr.hitObj1 | hr.hitObj2);
    score_sum = {1'b0, score_q} + PTS;
    score_sat = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
  end

  // Next-state logic. A counter load in PLAY leaves the frame counter alone
  // that cycle, so a coincident startOfFrame is simply not acted on.
  always_comb begin
    state_d  = state_q;
    lives_d  = lives_q;
    score_d  = score_q;
    bounce_d = 1'b0;
    inv_d    = inv_q;
    vis_d    = vis_q;
    over_d   = over_q;
    fc_d     = fc_q;
    bc_d     = bc_q;
    case (state_q)
      ST_PLAY: begin
        bounce_d = any_hit;
        if (rew_hit) begin
          score_d = score_sat;
        end
        if (dmg_hit) begin
          if (lives_q > LIVES_ONE) begin
            lives_d = lives_q - LIVES_ONE;
            state_d = ST_INVULN;
            fc_d    = FC_LOAD;
            bc_d    = '0;
            vis_d   = 1'b0;
            inv_d   = 1'b1;
          end else begin
            lives_d = '0;
            state_d = ST_OVER;
            over_d  = 1'b1;
            vis_d   = 1'b0;
            inv_d   = 1'b0;
          end
        end
      end
      ST_INVULN: begin
        bounce_d = any_hit;
        if (rew_hit) begin
          score_d = score_sat;
        end
        if (hr.startOfFrame) begin
          fc_d = fc_q - FC_ONE;
          if (fc_q == FC_ONE) begin
            state_d = ST_PLAY;
            inv_d   = 1'b0;
            vis_d   = 1'b1;
            bc_d    = '0;
          end else if (bc_q == BC_LAST) begin
            bc_d  = '0;
            vis_d = ~vis_q;
          end else begin
            bc_d = bc_q + BC_ONE;
          end
        end
      end
      ST_OVER: begin
        vis_d = 1'b0;
        inv_d = 1'b0;
        if (hr.restart) begin
          state_d = ST_PLAY;
          lives_d = LIVES_INIT;
          score_d = '0;
          over_d  = 1'b0;
          vis_d   = 1'b1;
        end
      end
      default: begin
        state_d = ST_PLAY;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_PLAY;
      lives_q  <= LIVES_INIT;
      score_q  <= '0;
      bounce_q <= 1'b0;
      inv_q    <= 1'b0;
      vis_q    <= 1'b1;
      over_q   <= 1'b0;
      fc_q     <= '0;
      bc_q     <= '0;
    end else begin
      state_q  <= state_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      bounce_q <= bounce_d;
      inv_q    <= inv_d;
      vis_q    <= vis_d;
      over_q   <= over_d;
      fc_q     <= fc_d;
      bc_q     <= bc_d;
    end
  end

  assign hr.lives        = lives_q;
  assign hr.score        = score_q;
  assign hr.bounce       = bounce_q;
  assign hr.invulnerable = inv_q;
  assign hr.ballVisible  = vis_q;
  assign hr.gameOver     = over_q;

endmodule

// File: tb/tb_hit_responder.sv
// Testbench for hit_responder: two instances (default sizing, and a narrow
// score / short window variant) share one stimulus stream and are compared
// every cycle against a frame-count based reference model.
module tb_hit_responder;

  typedef struct {
    int lives;
    int score;
    bit over;
    bit inv;
    int elapsed;
    bit bounce;
  } model_t;

  typedef struct {
    int init_lives;
    int score_max;
    int points;
    int frames;
    int blink;
  } cfg_t;

  typedef struct {
    bit sof, hp, o1, o2, rs;
    int lives, score;
    bit bounce, inv, vis, over;
  } vec_t;

  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  cfg_t   ca, cb;
  model_t ma, mb;
  bit     sof_r, hp_r, o1_r, o2_r, rs_r;

  hit_responder_if #(.LIVES_W(3), .SCORE_W(10)) ifa ();
  hit_responder_if #(.LIVES_W(3), .SCORE_W(4))  ifb ();

  hit_responder #(
    .INIT_LIVES(3), .LIVES_W(3), .SCORE_W(10), .POINTS(5),
    .INVULN_FRAMES(30), .BLINK_FRAMES(4)
  ) u_dut_a (
    .clk(clk), .reset(reset), .hr(ifa)
  );

  hit_responder #(
    .INIT_LIVES(3), .LIVES_W(3), .SCORE_W(4), .POINTS(5),
    .INVULN_FRAMES(3), .BLINK_FRAMES(1)
  ) u_dut_b (
    .clk(clk), .reset(reset), .hr(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic model_t mreset(cfg_t c);
    model_t m;
    m.lives = c.init_lives; m.score = 0; m.over = 0;
    m.inv = 0; m.elapsed = 0; m.bounce = 0;
    return m;
  endfunction

  function automatic model_t mstep(model_t m, cfg_t c, bit sof, bit hp, bit o1, bit o2, bit rs);
    m.bounce = 0;
    if (m.over) begin
      if (rs) begin
        m.over = 0; m.lives = c.init_lives; m.score = 0;
      end
    end else begin
      if (hp && (o1 || o2)) m.bounce = 1;
      if (hp && o2 && !o1)
        m.score = (m.score + c.points > c.score_max) ? c.score_max : m.score + c.points;
      if (m.inv) begin
        if (sof) begin
          m.elapsed++;
          if (m.elapsed >= c.frames) m.inv = 0;
        end
      end else if (hp && o1) begin
        if (m.lives > 1) begin
          m.lives--; m.inv = 1; m.elapsed = 0;
        end else begin
          m.lives = 0; m.over = 1;
        end
      end
    end
    return m;
  endfunction

  function automatic bit mvis(model_t m, cfg_t c);
    if (m.over) return 0;
    if (m.inv) return ((m.elapsed / c.blink) % 2) == 1;
    return 1;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cmp_models();
    chk("A.lives",  ifa.lives,        ma.lives);
    chk("A.score",  ifa.score,        ma.score);
    chk("A.bounce", ifa.bounce,       ma.bounce);
    chk("A.inv",    ifa.invulnerable, ma.inv);
    chk("A.vis",    ifa.ballVisible,  mvis(ma, ca));
    chk("A.over",   ifa.gameOver,     ma.over);
    chk("B.lives",  ifb.lives,        mb.lives);
    chk("B.score",  ifb.score,        mb.score);
    chk("B.bounce", ifb.bounce,       mb.bounce);
    chk("B.inv",    ifb.invulnerable, mb.inv);
    chk("B.vis",    ifb.ballVisible,  mvis(mb, cb));
    chk("B.over",   ifb.gameOver,     mb.over);
  endtask

  task automatic drive(bit s, bit h, bit a, bit b, bit r);
    sof_r = s; hp_r = h; o1_r = a; o2_r = b; rs_r = r;
    ifa.startOfFrame = s; ifa.hitPulse = h; ifa.hitObj1 = a; ifa.hitObj2 = b; ifa.restart = r;
    ifb.startOfFrame = s; ifb.hitPulse = h; ifb.hitObj1 = a; ifb.hitObj2 = b; ifb.restart = r;
  endtask

  // One clock with the given inputs; outputs sampled 1 time unit after the edge.
  task automatic step(bit s, bit h, bit a, bit b, bit r);
    drive(s, h, a, b, r);
    @(posedge clk);
    ma = mstep(ma, ca, sof_r, hp_r, o1_r, o2_r, rs_r);
    mb = mstep(mb, cb, sof_r, hp_r, o1_r, o2_r, rs_r);
    #1;
    cmp_models();
    drive(0, 0, 0, 0, 0);
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, ".lives"},  ifa.lives,        3);
    chk({tag, ".score"},  ifa.score,        0);
    chk({tag, ".bounce"}, ifa.bounce,       0);
    chk({tag, ".inv"},    ifa.invulnerable, 0);
    chk({tag, ".vis"},    ifa.ballVisible,  1);
    chk({tag, ".over"},   ifa.gameOver,     0);
  endtask

  // Mid-cycle reset, held across an edge that carries a damaging hit, then
  // released together with that hit.
  task automatic async_reset();
    #2;
    reset = 1'b1;
    ma = mreset(ca);
    mb = mreset(cb);
    #1;
    chk_reset_vals("arst");
    cmp_models();
    drive(1, 1, 1, 0, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0);
    chk_reset_vals("arst_hold");
  endtask

  vec_t tbl[15];

  initial begin
    //               sof hp o1 o2 rs  lives score bnc inv vis over
    tbl[0]  = '{0, 0, 0, 0, 0,  3,  0, 0, 0, 1, 0};
    tbl[1]  = '{0, 1, 0, 1, 0,  3,  5, 1, 0, 1, 0};
    tbl[2]  = '{1, 0, 0, 0, 0,  3,  5, 0, 0, 1, 0};
    tbl[3]  = '{0, 1, 0, 1, 0,  3, 10, 1, 0, 1, 0};
    tbl[4]  = '{1, 0, 0, 0, 0,  3, 10, 0, 0, 1, 0};
    tbl[5]  = '{0, 1, 0, 1, 0,  3, 15, 1, 0, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 0,  3, 15, 0, 0, 1, 0};
    tbl[7]  = '{0, 1, 0, 0, 0,  3, 15, 0, 0, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 1,  3, 15, 0, 0, 1, 0};
    tbl[9]  = '{1, 1, 1, 0, 0,  2, 15, 1, 1, 0, 0};
    tbl[10] = '{1, 0, 0, 0, 0,  2, 15, 0, 1, 0, 0};
    tbl[11] = '{1, 1, 1, 0, 0,  2, 15, 1, 1, 0, 0};
    tbl[12] = '{1, 1, 0, 1, 0,  2, 20, 1, 1, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 0,  2, 20, 0, 1, 1, 0};
    tbl[14] = '{0, 0, 0, 0, 1,  2, 20, 0, 1, 1, 0};

    ca = '{3, 1023, 5, 30, 4};
    cb = '{3, 15, 5, 3, 1};
    reset = 1'b1;
    drive(0, 0, 0, 0, 0);
    ma = mreset(ca);
    mb = mreset(cb);
    repeat (2) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    reset = 1'b0;

    // Directed table: reward hits, no-op hits, load-wins, non-reloading hit.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].sof, tbl[i].hp, tbl[i].o1, tbl[i].o2, tbl[i].rs);
      chk($sformatf("vec%0d.lives", i),  ifa.lives,        tbl[i].lives);
      chk($sformatf("vec%0d.score", i),  ifa.score,        tbl[i].score);
      chk($sformatf("vec%0d.bounce", i), ifa.bounce,       tbl[i].bounce);
      chk($sformatf("vec%0d.inv", i),    ifa.invulnerable, tbl[i].inv);
      chk($sformatf("vec%0d.vis", i),    ifa.ballVisible,  tbl[i].vis);
      chk($sformatf("vec%0d.over", i),   ifa.gameOver,     tbl[i].over);
    end

    // Finish the window: 4 frames elapsed so far, 30 in total from the first hit.
    for (int e = 5; e <= 30; e++) begin
      step(1, 0, 0, 0, 0);
      chk($sformatf("win%0d.vis", e), ifa.ballVisible,  (e == 30) ? 1 : (e / 4) % 2);
      chk($sformatf("win%0d.inv", e), ifa.invulnerable, (e < 30) ? 1 : 0);
      step(0, 0, 0, 0, 0);
    end

    // Down to the last life, then game over.
    step(0, 1, 1, 0, 0);
    chk("l1.lives", ifa.lives, 1);
    chk("l1.inv",   ifa.invulnerable, 1);
    for (int f = 0; f < 30; f++) step(1, 0, 0, 0, 0);
    chk("l1end.inv", ifa.invulnerable, 0);
    step(0, 1, 1, 0, 0);
    chk("over.lives",  ifa.lives, 0);
    chk("over.flag",   ifa.gameOver, 1);
    chk("over.vis",    ifa.ballVisible, 0);
    chk("over.bounce", ifa.bounce, 1);
    step(1, 1, 0, 1, 0);
    chk("over_hit.bounce", ifa.bounce, 0);
    chk("over_hit.score",  ifa.score, 20);
    step(0, 1, 1, 0, 1);
    chk("restart.lives",  ifa.lives, 3);
    chk("restart.score",  ifa.score, 0);
    chk("restart.over",   ifa.gameOver, 0);
    chk("restart.vis",    ifa.ballVisible, 1);
    chk("restart.bounce", ifa.bounce, 0);

    // Saturation on the 4-bit score instance, then both qualifiers together.
    for (int k = 1; k <= 4; k++) begin
      step(0, 1, 0, 1, 0);
      chk($sformatf("sat%0d.B", k), ifb.score, (k == 4) ? 15 : 5 * k);
      chk($sformatf("sat%0d.A", k), ifa.score, 5 * k);
      step(1, 0, 0, 0, 0);
    end
    step(0, 1, 1, 1, 0);
    chk("both.B.lives", ifb.lives, 2);
    chk("both.B.score", ifb.score, 15);
    chk("both.A.lives", ifa.lives, 2);
    chk("both.A.score", ifa.score, 20);

    // Bring the window counter down to 12 and reset in the middle of it.
    for (int f = 0; f < 18; f++) step(1, 0, 0, 0, 0);
    chk("pre_rst.inv", ifa.invulnerable, 1);
    async_reset();
    step(0, 0, 0, 0, 0);
    chk("post_rst.lives", ifa.lives, 3);
    chk("post_rst.inv",   ifa.invulnerable, 0);
    step(0, 1, 1, 0, 0);
    chk("post_rst_hit.lives", ifa.lives, 2);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        async_reset();
      end else begin
        step($urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 4) == 0, $urandom_range(0, 1) == 0,
             $urandom_range(0, 15) == 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/hit_responder.md
Name: hit_responder

Overview:
- Consumes the once-per-frame collision pulse and the per-object hit qualifiers produced by the collision controller.
- Converts them into game consequences: life loss, score gain, ball bounce request, a post-hit invulnerability window with blinking, and game-over/restart.
- Sits between the collision logic and the ball/score/HUD drawing units.
- All outputs are registered.

Parameters:
INIT_LIVES, 3, lives loaded at reset and restart (must be 1..2^LIVES_W-1)
LIVES_W, 3, width of lives output
SCORE_W, 10, width of score output
POINTS, 5, score added per reward hit
INVULN_FRAMES, 30, frames of invulnerability after a damaging hit (>=1)
BLINK_FRAMES, 4, frames per ball visibility toggle during invulnerability (>=1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
startOfFrame  in  1  one-cycle pulse at start of each frame
hitPulse  in  1  one-cycle pulse, at most one per frame, marks a collision
hitObj1  in  1  qualifier sampled with hitPulse: damaging object involved
hitObj2  in  1  qualifier sampled with hitPulse: reward object involved
restart  in  1  one-cycle request to start a new game
lives  out  LIVES_W  remaining lives
score  out  SCORE_W  accumulated score, saturating
bounce  out  1  one-cycle pulse requesting ball direction reversal
invulnerable  out  1  high while damage is being ignored
ballVisible  out  1  ball draw enable
gameOver  out  1  high in OVER state

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state=PLAY, lives=INIT_LIVES, score=0
  - bounce=0, invulnerable=0, ballVisible=1, gameOver=0
  - frame counter=0, blink counter=0
- States:
  - PLAY: normal play.
  - INVULN: damage ignored.
  - OVER: game ended.
- Latency: every output reflects an event one clock after the cycle in which hitPulse/restart/startOfFrame is high.
- Qualifiers are ignored unless hitPulse=1. hitPulse with both qualifiers low does nothing.
- bounce: one-cycle pulse on any hitPulse with hitObj1 or hitObj2 high, in PLAY or INVULN. Never asserted in OVER.
- PLAY, hitPulse & hitObj1:
  - lives>1: lives-1, go to INVULN, frame counter=INVULN_FRAMES, blink counter=0, ballVisible=0, invulnerable=1.
  - lives==1: lives=0, go to OVER, gameOver=1.
- Both qualifiers high: hitObj1 takes priority; no score is added that cycle.
- PLAY or INVULN, hitPulse & hitObj2 & !hitObj1: score += POINTS, saturating at 2^SCORE_W-1. No wrap.
- INVULN, hitPulse & hitObj1: lives unchanged, counter not reloaded, bounce still pulses.
- INVULN, on each startOfFrame:
  - Frame counter decrements.
  - Blink counter increments; when it reaches BLINK_FRAMES it clears to 0 and ballVisible toggles.
  - When the counter decrements from 1 to 0: go to PLAY, invulnerable=0, ballVisible=1 (same update).
- startOfFrame coincident with the hitPulse that loads the counter: the load wins; no decrement that cycle.
- startOfFrame coincident with a non-loading hitPulse in INVULN: both take effect.
- OVER:
  - ballVisible=0, invulnerable=0; lives and score frozen.
  - hitPulse ignored.
  - restart: lives=INIT_LIVES, score=0, gameOver=0, ballVisible=1, go to PLAY.
- restart in PLAY/INVULN is ignored.
- restart coincident with hitPulse in OVER: restart applies; the hit is ignored.
- Counters are sized ceil(log2(max+1)). No combinational path from input to output.

Test Plan:
- Reset, then hitPulse+hitObj2 three times in separate frames -> score=15, lives=3, bounce pulses 3 times, each one cycle after the hit.
- In PLAY with lives=3, hitPulse+hitObj1 -> next cycle lives=2, invulnerable=1, ballVisible=0. ballVisible toggles every 4 startOfFrame pulses. After 30 startOfFrame pulses: invulnerable=0, ballVisible=1, state PLAY.
- During INVULN, hitPulse+hitObj1 -> lives stays 2, bounce pulses, window still ends 30 frames after the first hit.
- Three damaging hits, each after the window expires -> lives 3->2->1->0, gameOver=1, ballVisible=0. A further hitPulse gives no bounce. restart -> lives=3, score=0, gameOver=0.
- Score preloaded near saturation (SCORE_W=4, POINTS=5): hits give 5,10,15,15 -> saturation holds. hitPulse with both qualifiers high -> life lost, score unchanged.
- Assert reset mid-INVULN with counter=12 -> all outputs immediately at reset values, state PLAY, lives=INIT_LIVES. A hit on the same cycle that reset is released is ignored.
